// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences lw/sw/R/addi/beq,
// halts on unsupported encodings and counts retired instructions.
module multicycle_control #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         inst,
  input  logic                zero,
  output logic                PCWrite,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                PCSource,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic                RegWrite,
  output logic [3:0]          ALUControl,
  output logic [3:0]          state,
  output logic                halted,
  output logic [RETIRE_W-1:0] instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_BRANCH_NT = 4'd10,
    S_HALT      = 4'd11
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_e                state_q, state_d;
  logic [RETIRE_W-1:0]   ret_q;
  logic                  retire;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7;
  logic       is_lw, is_sw, is_r, is_addi, is_beq;
  logic       r_ok;
  logic [3:0] r_ctl;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[30];

  assign is_lw   = (opc == 7'b0000011) && (f3 == 3'b010);
  assign is_sw   = (opc == 7'b0100011) && (f3 == 3'b010);
  assign is_r    = (opc == 7'b0110011);
  assign is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
  assign is_beq  = (opc == 7'b1100011) && (f3 == 3'b000);

  always_comb begin
    r_ok  = 1'b1;
    r_ctl = ALU_ADD;
    unique case (1'b1)
      (f3 == 3'b000) && !f7: r_ctl = ALU_ADD;
      (f3 == 3'b000) &&  f7: r_ctl = ALU_SUB;
      (f3 == 3'b111):        r_ctl = ALU_AND;
      (f3 == 3'b110):        r_ctl = ALU_OR;
      default:               r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_HALT;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_lw || is_sw: state_d = S_MEMADR;
          is_r:           state_d = S_EXEC_R;
          is_addi:        state_d = S_EXEC_I;
          is_beq:         state_d = S_BRANCH;
          default:        state_d = S_HALT;
        endcase
      end
      S_MEMADR:  state_d = is_sw ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_d = S_MEMWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH_NT: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_EXEC_R: state_d = r_ok ? S_ALUWB : S_HALT;
      S_EXEC_I: state_d = S_ALUWB;
      S_BRANCH: begin
        state_d = zero ? S_FETCH : S_BRANCH_NT;
        retire  = zero;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) ret_q <= ret_q + RETIRE_W'(1);
    end
  end

  logic pc_we, mem_re, mem_we, ir_we, rf_we;

  always_comb begin
    pc_we      = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    IorD       = 1'b0;
    MemtoReg   = 1'b0;
    PCSource   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_re = 1'b1;
        ir_we  = 1'b1;
      end
      S_DECODE: ALUSrcB = 2'b10;
      S_MEMADR, S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: begin
        IorD   = 1'b1;
        mem_re = 1'b1;
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        MemtoReg = 1'b1;
        pc_we    = 1'b1;
        ALUSrcB  = 2'b01;
      end
      S_MEMWRITE: begin
        IorD    = 1'b1;
        mem_we  = 1'b1;
        pc_we   = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUControl = r_ctl;
      end
      S_ALUWB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        ALUSrcB = 2'b01;
      end
      // Taken branch loads the target computed in DECODE
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        pc_we      = zero;
        PCSource   = 1'b1;
      end
      S_BRANCH_NT: begin
        pc_we   = 1'b1;
        ALUSrcB = 2'b01;
      end
      default: ;
    endcase
  end

  assign PCWrite       = pc_we  & reset;
  assign MemRead       = mem_re & reset;
  assign MemWrite      = mem_we & reset;
  assign IRWrite       = ir_we  & reset;
  assign RegWrite      = rf_we  & reset;
  assign state         = state_q;
  assign halted        = (state_q == S_HALT);
  assign instr_retired = ret_q;

endmodule
